mem_rd_arbiter: RTL and testbench
=================================

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, AXI read address width.
REQ-002 SHALL have parameter DATA_W, default 64, read data width.
REQ-003 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-004 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  in  2  refill request valid; bit0 = I$, bit1 = D$.
REQ-007 SHALL have port req_ready_o  in/out: out  2  request accepted (one-hot or zero).
REQ-008 SHALL have port req_addr_i  in  2xADDR_W  per-requester line address.
REQ-009 SHALL have port req_len_i  in  2x4  per-requester beats minus one.
REQ-010 SHALL have port ar_valid_o / ar_ready_i  out / in  1 / 1  AR handshake.
REQ-011 SHALL have port ar_addr_o, ar_len_o, ar_id_o  out  ADDR_W, 8, ID_W  AR payload.
REQ-012 SHALL have port r_valid_i / r_ready_o  in / out  1 / 1  R handshake.
REQ-013 SHALL have port r_data_i, r_last_i, r_id_i  in  DATA_W, 1, ID_W  R payload.
REQ-014 SHALL have port rsp_valid_o  out  2  beat valid to owner only; rsp_ready_i  in  2  owner beat acceptance.
REQ-015 SHALL have port rsp_data_o, rsp_last_o  out  DATA_W, 1  shared beat payload.
REQ-016 SHALL have port busy_o  out  1  state != IDLE; err_o  out  1  sticky protocol error.

Function
REQ-017 SHALL implement states IDLE, ADDR, DATA; at most one transaction outstanding.
REQ-018 IDLE: if any req_valid_i, SHALL grant one requester, assert its req_ready_o same cycle, latch addr/len/owner, go ADDR.
REQ-019 Grant SHALL be round-robin: both valid -> requester not granted last; after reset I$ has priority.
REQ-020 ADDR: ar_valid_o=1, payload stable; ar_len_o = zero-extended latched len; ar_id_o = owner index; on ar_ready_i go DATA.
REQ-021 DATA: r_ready_o = rsp_ready_i[owner]; rsp_valid_o[owner] = r_valid_i; other rsp_valid_o bit 0.
REQ-022 Beat counter (4 bits) SHALL increment on each R handshake with matching id, clearing on entry to DATA.
REQ-023 R beat with r_id_i != latched id SHALL be consumed (r_ready_o=1), not forwarded, and set err_o.
REQ-024 Transaction SHALL end on handshaked r_last_i with matching id; next state IDLE; round-robin pointer updated.
REQ-025 r_last_i with count != len, or beat count exceeding len without r_last_i, SHALL set err_o; counter saturates at 15.
REQ-026 Latency: request accepted cycle N -> ar_valid_o cycle N+1; last beat cycle M -> earliest next grant cycle M+1.
REQ-027 req_ready_o SHALL be 0 outside IDLE; requests arriving during ADDR/DATA wait without loss.
REQ-028 err_o SHALL remain 1 until reset; it SHALL NOT stall the state machine.

Reset
REQ-029 On rst_i high at a clock edge: state IDLE, rr pointer to I$, counter 0, err_o 0.
REQ-030 After reset all outputs SHALL be 0 (req_ready_o, ar_valid_o, r_ready_o, rsp_valid_o, busy_o, err_o); payload outputs 0.
REQ-031 Reset mid-transaction SHALL abandon it; in-flight R beats afterwards are treated as mismatched-id beats only once a new transaction is in DATA.

Structure
REQ-032 Package mem_rd_arb_pkg SHALL hold the state enum, the requester index constants, and the default widths.
REQ-033 Round-robin selection SHALL be a sub-module rr_arb2 (2 requesters, grant + pointer update input).

Verification
REQ-034 Single I$ request addr 0x8000_0040 len 7, ar_ready same cycle -> AR id 0 len 7, 8 beats to rsp_valid_o[0], err_o 0.
REQ-035 Both valid in IDLE after reset -> I$ granted first, D$ granted cycle after I$ last beat; repeat -> alternation.
REQ-036 rsp_ready_i[owner] low for 3 cycles mid-burst -> r_ready_o low 3 cycles, no beat lost or duplicated.
REQ-037 r_last_i on beat 4 of len 7 -> err_o 1, return to IDLE, next request served normally.
REQ-038 Beat with r_id_i 1 during id-0 transaction -> beat dropped, rsp_valid_o 0 that cycle, err_o 1.
REQ-039 rst_i asserted in DATA after 2 beats -> next cycle all outputs 0, state IDLE, err_o 0.

Source files
------------

// File: rtl/mem_rd_arb_pkg.sv
// Shared definitions for the cache refill read arbiter.
// Holds the FSM state encoding, the requester index constants and the
// default bus widths used by mem_rd_arbiter and rr_arb2.
package mem_rd_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 64;
   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned ID_W_DEF   = 4;

   // Requester indices; the index doubles as the AXI ID of the request.
   localparam logic REQ_IC = 1'b0;
   localparam logic REQ_DC = 1'b1;

   localparam logic [3:0] CNT_MAX = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : request vector (bit0 = I$, bit1 = D$)
//   upd_i        : pulse when the granted transaction completes
//   upd_idx_i    : index of the requester whose transaction completed
//   gnt_o        : one-hot grant (zero when no request)
//   gnt_idx_o    : index of the granted requester
module rr_arb2
   import mem_rd_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   input  logic       upd_idx_i,
   output logic [1:0] gnt_o,
   output logic       gnt_idx_o
);

   // Index of the requester that wins when both are requesting.
   logic prio_q;
   logic prio_d;

   // Priority moves to the requester that did not just complete.
   always_comb begin
      prio_d = prio_q;
      if (upd_i) begin
         prio_d = ~upd_idx_i;
      end else begin
         prio_d = prio_q;
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= REQ_IC;
      end else begin
         prio_q <= prio_d;
      end
   end

   // Grant selection: a lone requester always wins, contention uses prio_q.
   always_comb begin
      gnt_idx_o = REQ_IC;
      gnt_o     = 2'b00;
      case (req_i)
         2'b01:   gnt_idx_o = REQ_IC;
         2'b10:   gnt_idx_o = REQ_DC;
         2'b11:   gnt_idx_o = prio_q;
         default: gnt_idx_o = REQ_IC;
      endcase
      if (req_i != 2'b00) begin
         gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
      end else begin
         gnt_o = 2'b00;
      end
   end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Refill read arbiter: shares one AXI read channel between the I$ and D$.
// One transaction outstanding at a time; requesters granted round-robin.
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   req_valid_i/req_ready_o           : per-requester refill handshake
//   req_addr_i/req_len_i              : per-requester line address, beats-1
//   ar_valid_o/ar_ready_i, ar_*_o     : AXI AR channel
//   r_valid_i/r_ready_o, r_*_i        : AXI R channel
//   rsp_valid_o/rsp_ready_i           : per-requester beat handshake
//   rsp_data_o/rsp_last_o             : shared beat payload
//   busy_o                            : transaction in progress
//   err_o                             : sticky protocol error
module mem_rd_arbiter
   import mem_rd_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ID_W   = ID_W_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [1:0]             req_valid_i,
   output logic [1:0]             req_ready_o,
   input  logic [1:0][ADDR_W-1:0] req_addr_i,
   input  logic [1:0][3:0]        req_len_i,
   output logic                   ar_valid_o,
   input  logic                   ar_ready_i,
   output logic [ADDR_W-1:0]      ar_addr_o,
   output logic [7:0]             ar_len_o,
   output logic [ID_W-1:0]        ar_id_o,
   input  logic                   r_valid_i,
   output logic                   r_ready_o,
   input  logic [DATA_W-1:0]      r_data_i,
   input  logic                   r_last_i,
   input  logic [ID_W-1:0]        r_id_i,
   output logic [1:0]             rsp_valid_o,
   input  logic [1:0]             rsp_ready_i,
   output logic [DATA_W-1:0]      rsp_data_o,
   output logic                   rsp_last_o,
   output logic                   busy_o,
   output logic                   err_o
);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [3:0]        len_q,   len_d;
   logic [3:0]        cnt_q,   cnt_d;
   logic              err_q,   err_d;

   logic [1:0] gnt_s;
   logic       gnt_idx_s;
   logic       rr_upd_s;
   logic       id_match_s;

   rr_arb2 u_rr_arb2 (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_valid_i),
      .upd_i     (rr_upd_s),
      .upd_idx_i (owner_q),
      .gnt_o     (gnt_s),
      .gnt_idx_o (gnt_idx_s)
   );

   // The owner index is also the AXI ID used for the transaction.
   assign id_match_s = (r_id_i == ID_W'(owner_q));

   // Next-state and output decode; payload outputs are held at zero
   // outside the state that drives them.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rr_upd_s    = 1'b0;
      req_ready_o = 2'b00;
      ar_valid_o  = 1'b0;
      ar_addr_o   = '0;
      ar_len_o    = 8'd0;
      ar_id_o     = '0;
      r_ready_o   = 1'b0;
      rsp_valid_o = 2'b00;
      rsp_data_o  = '0;
      rsp_last_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid_i) begin
               req_ready_o = gnt_s;
               owner_d     = gnt_idx_s;
               addr_d      = req_addr_i[gnt_idx_s];
               len_d       = req_len_i[gnt_idx_s];
               state_d     = ST_ADDR;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_ADDR: begin
            ar_valid_o = 1'b1;
            ar_addr_o  = addr_q;
            ar_len_o   = {4'd0, len_q};
            ar_id_o    = ID_W'(owner_q);
            if (ar_ready_i) begin
               cnt_d   = 4'd0;
               state_d = ST_DATA;
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (id_match_s) begin
               r_ready_o            = rsp_ready_i[owner_q];
               rsp_valid_o[owner_q] = r_valid_i;
               rsp_data_o           = r_data_i;
               rsp_last_o           = r_last_i;
               if (r_valid_i && rsp_ready_i[owner_q]) begin
                  cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + 4'd1);
                  if (r_last_i) begin
                     // Burst ends here regardless of length; short bursts flag an error.
                     err_d    = (cnt_q != len_q) ? 1'b1 : err_q;
                     rr_upd_s = 1'b1;
                     state_d  = ST_IDLE;
                  end else begin
                     // The beat at index len must carry r_last.
                     err_d    = (cnt_q >= len_q) ? 1'b1 : err_q;
                     state_d  = ST_DATA;
                  end
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               // Foreign-ID beats are drained so they cannot block the channel.
               r_ready_o = 1'b1;
               if (r_valid_i) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
               state_d = ST_DATA;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and transaction context registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         owner_q <= REQ_IC;
         addr_q  <= '0;
         len_q   <= 4'd0;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign busy_o = (state_q != ST_IDLE);
   assign err_o  = err_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: directed table, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_mem_rd_arbiter;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [1:0]       req_valid_i;
   logic [1:0]       req_ready_o;
   logic [1:0][63:0] req_addr_i;
   logic [1:0][3:0]  req_len_i;
   logic             ar_valid_o;
   logic             ar_ready_i;
   logic [63:0]      ar_addr_o;
   logic [7:0]       ar_len_o;
   logic [3:0]       ar_id_o;
   logic             r_valid_i;
   logic             r_ready_o;
   logic [63:0]      r_data_i;
   logic             r_last_i;
   logic [3:0]       r_id_i;
   logic [1:0]       rsp_valid_o;
   logic [1:0]       rsp_ready_i;
   logic [63:0]      rsp_data_o;
   logic             rsp_last_o;
   logic             busy_o;
   logic             err_o;

   mem_rd_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_len_i(req_len_i),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
      .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_id_o(ar_id_o),
      .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
      .r_data_i(r_data_i), .r_last_i(r_last_i), .r_id_i(r_id_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  vld;
      logic [63:0] a0;
      logic [63:0] a1;
      logic [3:0]  l0;
      logic [3:0]  l1;
      int          exp_g;
   } vec_t;

   vec_t        tbl [8];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] t_addr [2];
   logic [3:0]  t_len [2];
   int          last_g = 1;     // model: requester granted last (reset favours I$)
   bit          exp_err = 1'b0; // model: sticky error expectation

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Round-robin rule: lone requester wins, contention goes to the other one.
   function automatic int rr_pick(input logic [1:0] v);
      if (v == 2'b11) return 1 - last_g;
      else if (v[0]) return 0;
      else return 1;
   endfunction

   task automatic idle_inputs();
      req_valid_i = 2'b00; ar_ready_i = 1'b0; r_valid_i = 1'b0; r_last_i = 1'b0;
      r_id_i = 4'd0; r_data_i = 64'd0; rsp_ready_i = 2'b00;
      req_addr_i[0] = 64'd0; req_addr_i[1] = 64'd0; req_len_i[0] = 4'd0; req_len_i[1] = 4'd0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready_o, 64'd0);
      chk({tag, "_ar_valid"},  ar_valid_o,  64'd0);
      chk({tag, "_ar_addr"},   ar_addr_o,   64'd0);
      chk({tag, "_ar_len"},    ar_len_o,    64'd0);
      chk({tag, "_ar_id"},     ar_id_o,     64'd0);
      chk({tag, "_r_ready"},   r_ready_o,   64'd0);
      chk({tag, "_rsp_valid"}, rsp_valid_o, 64'd0);
      chk({tag, "_rsp_data"},  rsp_data_o,  64'd0);
      chk({tag, "_rsp_last"},  rsp_last_o,  64'd0);
      chk({tag, "_busy"},      busy_o,      64'd0);
      chk({tag, "_err"},       err_o,       64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      idle_inputs();
      rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      last_g = 1;
      exp_err = 1'b0;
   endtask

   // One complete refill: grant, AR handshake, beats until the last one.
   // stall_at: beat index at which the owner withholds rsp_ready for 3 cycles.
   // early_at: beat index that carries r_last early.
   // bad_at:   beat index preceded by one foreign-ID beat.
   task automatic do_txn(input logic [1:0] vld, input int g, input bit rnd,
                         input int stall_at, input int early_at, input int bad_at);
      int          waits, k, guard, stall_left, end_idx;
      bit          bad_done;
      logic [63:0] d;
      logic [1:0]  oh;
      oh = (g == 0) ? 2'b01 : 2'b10;
      end_idx = (early_at >= 0) ? early_at : int'(t_len[g]);
      req_valid_i = vld;
      req_addr_i[0] = t_addr[0]; req_addr_i[1] = t_addr[1];
      req_len_i[0]  = t_len[0];  req_len_i[1]  = t_len[1];
      #1;
      chk("grant", req_ready_o, oh);
      chk("busy_idle", busy_o, 64'd0);
      @(negedge clk_i);
      req_valid_i[g] = 1'b0;
      waits = rnd ? $urandom_range(0, 3) : 0;
      repeat (waits) begin
         #1;
         chk("ar_wait_valid", ar_valid_o, 64'd1);
         chk("req_ready_addr", req_ready_o, 64'd0);
         @(negedge clk_i);
      end
      ar_ready_i = 1'b1;
      #1;
      chk("ar_valid", ar_valid_o, 64'd1);
      chk("ar_addr", ar_addr_o, t_addr[g]);
      chk("ar_len", ar_len_o, {60'd0, t_len[g]});
      chk("ar_id", ar_id_o, g);
      chk("busy_addr", busy_o, 64'd1);
      chk("req_ready_addr", req_ready_o, 64'd0);
      @(negedge clk_i);
      ar_ready_i = 1'b0;
      k = 0; guard = 0; stall_left = 3; bad_done = 1'b0;
      d = {$urandom, $urandom};
      while (k <= end_idx && guard < 300) begin
         guard++;
         r_data_i = d;
         r_last_i = (k == end_idx);
         if (k == bad_at && !bad_done) begin
            r_valid_i = 1'b1;
            r_id_i = (g == 0) ? 4'd1 : 4'd0;
            rsp_ready_i = 2'b00;
            #1;
            chk("bad_rsp_valid", rsp_valid_o, 64'd0);
            chk("bad_r_ready", r_ready_o, 64'd1);
            bad_done = 1'b1;
            exp_err = 1'b1;
         end else begin
            r_id_i = 4'(g);
            r_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            rsp_ready_i = rnd ? 2'($urandom_range(0, 3)) : 2'b11;
            if (k == stall_at && stall_left > 0) begin
               rsp_ready_i[g] = 1'b0;
               stall_left--;
            end
            #1;
            chk("rsp_valid", rsp_valid_o, r_valid_i ? oh : 2'b00);
            chk("r_ready", r_ready_o, rsp_ready_i[g]);
            chk("req_ready_data", req_ready_o, 64'd0);
            if (r_valid_i) begin
               chk("rsp_data", rsp_data_o, d);
               chk("rsp_last", rsp_last_o, r_last_i);
            end
            if (r_valid_i && rsp_ready_i[g]) begin
               k++;
               d = {$urandom, $urandom};
            end
         end
         @(negedge clk_i);
      end
      chk("beat_count", k, end_idx + 1);
      r_valid_i = 1'b0; r_last_i = 1'b0; rsp_ready_i = 2'b00;
      if (early_at >= 0) exp_err = 1'b1;
      last_g = g;
      #1;
      chk("busy_end", busy_o, 64'd0);
      chk("err", err_o, exp_err);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] pend, newv, v;
      int         g;
      rst_i = 1'b1;
      idle_inputs();

      // Directed vectors: request pattern, payloads and the expected winner.
      tbl[0] = '{2'b01, 64'h0000_0000_8000_0040, 64'h0,                   4'd7, 4'd0,  0};
      tbl[1] = '{2'b11, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_2000, 4'd1, 4'd2,  1};
      tbl[2] = '{2'b11, 64'h0000_0000_0000_3000, 64'h0000_0000_0000_4000, 4'd3, 4'd2,  0};
      tbl[3] = '{2'b10, 64'h0,                   64'hFFFF_FFFF_FFFF_FFC0, 4'd0, 4'd4,  1};
      tbl[4] = '{2'b10, 64'h0,                   64'h1234_5678_9ABC_DE00, 4'd0, 4'd1,  1};
      tbl[5] = '{2'b11, 64'h0000_0000_0000_5540, 64'h0000_0000_0000_6680, 4'd5, 4'd6,  0};
      tbl[6] = '{2'b01, 64'h0000_0000_0000_7700, 64'h0,                   4'd0, 4'd0,  0};
      tbl[7] = '{2'b11, 64'h0000_0000_0000_8800, 64'h0000_0000_0000_9900, 4'd2, 4'd15, 1};

      do_reset();
      #1;
      chk_all_zero("reset");

      for (int i = 0; i < 8; i++) begin
         t_addr[0] = tbl[i].a0; t_addr[1] = tbl[i].a1;
         t_len[0]  = tbl[i].l0; t_len[1]  = tbl[i].l1;
         do_txn(tbl[i].vld, tbl[i].exp_g, 1'b0, -1, -1, -1);
      end
      req_valid_i = 2'b00;

      // Both requesting right after reset: I$ first, D$ in the cycle after its last beat.
      do_reset();
      t_addr[0] = 64'h0000_0000_0000_0A00; t_len[0] = 4'd3;
      t_addr[1] = 64'h0000_0000_0000_0B00; t_len[1] = 4'd1;
      do_txn(2'b11, 0, 1'b0, -1, -1, -1);
      do_txn(req_valid_i, 1, 1'b0, -1, -1, -1);
      req_valid_i = 2'b00;

      // Owner back-pressure for 3 cycles mid-burst.
      t_addr[0] = 64'h0000_0000_8000_0040; t_len[0] = 4'd7;
      do_txn(2'b01, 0, 1'b0, 3, -1, -1);

      // r_last on the 4th beat of an 8-beat burst, then a normal request.
      do_txn(2'b01, 0, 1'b0, -1, 3, -1);
      t_len[1] = 4'd2;
      do_txn(2'b10, 1, 1'b0, -1, -1, -1);

      // Foreign-ID beat during an I$ transaction.
      do_reset();
      do_txn(2'b01, 0, 1'b0, -1, -1, 2);

      // Reset in DATA after two beats, with beats still arriving.
      req_valid_i = 2'b01;
      req_addr_i[0] = t_addr[0]; req_len_i[0] = 4'd7;
      #1;
      chk("mid_grant", req_ready_o, 64'd1);
      @(negedge clk_i);
      req_valid_i = 2'b00; ar_ready_i = 1'b1;
      @(negedge clk_i);
      ar_ready_i = 1'b0; r_valid_i = 1'b1; r_id_i = 4'd0; rsp_ready_i = 2'b11;
      r_data_i = 64'hDEAD_BEEF_0000_0001;
      @(negedge clk_i);
      r_data_i = 64'hDEAD_BEEF_0000_0002;
      @(negedge clk_i);
      rst_i = 1'b1; r_last_i = 1'b1; r_data_i = 64'hDEAD_BEEF_0000_0003;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      r_valid_i = 1'b0; r_last_i = 1'b0; rsp_ready_i = 2'b00;
      last_g = 1; exp_err = 1'b0;
      @(negedge clk_i);
      do_txn(2'b11, 0, 1'b0, -1, -1, -1);
      req_valid_i = 2'b00;

      // Randomized traffic against the round-robin model; losers keep requesting.
      do_reset();
      pend = 2'b00;
      for (int i = 0; i < 40; i++) begin
         newv = 2'($urandom_range(0, 3));
         if ((pend | newv) == 2'b00) newv = 2'b01;
         for (int j = 0; j < 2; j++) begin
            if (newv[j] && !pend[j]) begin
               t_addr[j] = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFC0;
               t_len[j]  = 4'($urandom_range(0, 15));
            end
         end
         v = pend | newv;
         g = rr_pick(v);
         do_txn(v, g, 1'b1, -1, -1, -1);
         pend = v & ((g == 0) ? 2'b10 : 2'b01);
      end
      req_valid_i = 2'b00;
      @(negedge clk_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
